// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control FSM.
// MC_JUMP_EN adds the JUMP state and the j opcode (0x02).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
`ifdef MC_JUMP_EN
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
`else
        S_BRANCH    = 4'd10
`endif
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_OR    = 3'b010,
        ALU_RTYPE = 3'b111
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ORI) ||
             (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_BNE);
`ifdef MC_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

    function automatic state_t op_target(input logic [5:0] op);
        state_t s;
        s = S_FETCH;
        if (op == OP_RTYPE)
            s = S_R_EXEC;
        else if (op == OP_ADDI || op == OP_ORI)
            s = S_I_EXEC;
        else if (op == OP_LW || op == OP_SW)
            s = S_MEM_ADDR;
        else if (op == OP_BEQ || op == OP_BNE)
            s = S_BRANCH;
`ifdef MC_JUMP_EN
        else if (op == OP_J)
            s = S_JUMP;
`endif
        return s;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts cycles spent waiting for memory; expires after LIMIT cycles.
module mc_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic done,
    output logic expired
);

    logic [7:0] count;

    assign expired = run && (count == 8'(LIMIT - 1));

    // Every exit from a wait state is done or expired, so this clears on each state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (!run || done || expired)
            count <= '0;
        else
            count <= count + 8'd1;
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with memory wait timeout.
// Define MC_JUMP_EN to enable the JUMP state for opcode 0x02.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond_eq,
    output logic        pc_write_cond_ne,
    output logic        ior_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_source,
    output logic [2:0]  alu_op,
    output logic [3:0]  state,
    output logic        bus_error,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    state_t     state_q;
    logic [5:0] op_q;
    logic       timeout;

    mc_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (is_wait(state_q)),
        .done    (mem_ready),
        .expired (timeout)
    );

    assign state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            op_q        <= '0;
            instr_count <= '0;
            bus_error   <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            bus_error  <= 1'b0;
            illegal_op <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (mem_ready)
                        state_q <= S_DECODE;
                    else if (timeout) begin
                        bus_error <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_DECODE: begin
                    op_q <= opcode;
                    if (op_legal(opcode))
                        state_q <= op_target(opcode);
                    else begin
                        illegal_op <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_MEM_ADDR:
                    state_q <= (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
                S_MEM_READ: begin
                    if (mem_ready)
                        state_q <= S_MEM_WB;
                    else if (timeout) begin
                        bus_error <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        instr_count <= instr_count + 32'd1;
                        state_q     <= S_FETCH;
                    end else if (timeout) begin
                        bus_error <= 1'b1;
                        state_q   <= S_FETCH;
                    end
                end
                S_R_EXEC: state_q <= S_R_WB;
                S_I_EXEC: state_q <= S_I_WB;
`ifdef MC_JUMP_EN
                S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: begin
`else
                S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH: begin
`endif
                    instr_count <= instr_count + 32'd1;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pc_write         = 1'b0;
        pc_write_cond_eq = 1'b0;
        pc_write_cond_ne = 1'b0;
        ior_d            = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        ir_write         = 1'b0;
        mem_to_reg       = 1'b0;
        reg_dst          = 1'b0;
        reg_write        = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = SRCB_REG;
        pc_source        = PC_ALU;
        alu_op           = ALU_ADD;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // Only strobes allowed to follow mem_ready; masked while in reset.
                ir_write  = mem_ready && !reset;
                pc_write  = mem_ready && !reset;
            end
            S_DECODE:
                alu_src_b = SRCB_BR;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                ior_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                ior_d     = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (op_q == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_I_WB:
                reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a        = 1'b1;
                alu_op           = ALU_SUB;
                pc_source        = PC_BRANCH;
                pc_write_cond_eq = (op_q == OP_BEQ);
                pc_write_cond_ne = (op_q == OP_BNE);
            end
`ifdef MC_JUMP_EN
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (TIMEOUT_CYCLES=4).
module tb_multicycle_control;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MW  = 4'd5;
    localparam logic [3:0] RE  = 4'd6;
    localparam logic [3:0] RW  = 4'd7;
    localparam logic [3:0] IE  = 4'd8;
    localparam logic [3:0] IW  = 4'd9;
    localparam logic [3:0] BR  = 4'd10;
    localparam logic [3:0] J   = 4'd11;
`ifdef MC_JUMP_EN
    localparam int JC = 1;
`else
    localparam int JC = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ready = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        pc_write, pc_write_cond_eq, pc_write_cond_ne, ior_d;
    logic        mem_read, mem_write, ir_write, mem_to_reg, reg_dst;
    logic        reg_write, alu_src_a, bus_error, illegal_op;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [17:0] word;
        logic [31:0] cnt;
        logic        be;
        logic        io;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    logic [17:0] m_w;
    int          total = 0;
    int          passed = 0;

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .opcode           (opcode),
        .mem_ready        (mem_ready),
        .pc_write         (pc_write),
        .pc_write_cond_eq (pc_write_cond_eq),
        .pc_write_cond_ne (pc_write_cond_ne),
        .ior_d            (ior_d),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .ir_write         (ir_write),
        .mem_to_reg       (mem_to_reg),
        .reg_dst          (reg_dst),
        .reg_write        (reg_write),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .pc_source        (pc_source),
        .alu_op           (alu_op),
        .state            (state),
        .bus_error        (bus_error),
        .illegal_op       (illegal_op),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    // Expected control word per state, straight from the state table.
    function automatic logic [17:0] ctl(input logic [3:0] st, input logic [5:0] op,
                                        input logic mr, input logic rs);
        logic pw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            F:   begin mrd = 1; sb = 2'b01; irw = mr & ~rs; pw = mr & ~rs; end
            D:   sb = 2'b11;
            MA:  begin sa = 1; sb = 2'b10; end
            MR:  begin mrd = 1; iord = 1; end
            MWB: begin rw = 1; m2r = 1; end
            MW:  begin mwr = 1; iord = 1; end
            RE:  begin sa = 1; ao = 3'b111; end
            RW:  begin rw = 1; rdst = 1; end
            IE:  begin sa = 1; sb = 2'b10; ao = (op == 6'h0D) ? 3'b010 : 3'b000; end
            IW:  rw = 1;
            BR:  begin
                sa = 1; ao = 3'b001; ps = 2'b01;
                eq = (op == 6'h04); ne = (op == 6'h05);
            end
            J:   begin pw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pw, eq, ne, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ps, ao};
    endfunction

    task automatic step(input string nm, input int mr, input int rs,
                        input logic [3:0] st, input int cnt, input int be, input int io);
        exp_t e;
        mem_ready = (mr != 0);
        reset     = (rs != 0);
        e.name = nm;
        e.st   = st;
        e.word = ctl(st, opcode, mr != 0, rs != 0);
        e.cnt  = cnt;
        e.be   = (be != 0);
        e.io   = (io != 0);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            m_w = {pc_write, pc_write_cond_eq, pc_write_cond_ne, ior_d, mem_read,
                   mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                   alu_src_b, pc_source, alu_op};
            total++;
            if (state === m_e.st && m_w === m_e.word && instr_count === m_e.cnt &&
                bus_error === m_e.be && illegal_op === m_e.io)
                passed++;
            else
                $display("FAIL %s: got st=%0d ctl=%05h cnt=%0d be=%b io=%b, want st=%0d ctl=%05h cnt=%0d be=%b io=%b",
                         m_e.name, state, m_w, instr_count, bus_error, illegal_op,
                         m_e.st, m_e.word, m_e.cnt, m_e.be, m_e.io);
        end
    end

    initial begin
        @(posedge clk); #1;
        step("reset", 1, 1, F, 0, 0, 0);
        step("reset_hold", 1, 1, F, 0, 0, 0);
        opcode = 6'h08;
        step("addi_f", 1, 0, F, 0, 0, 0);
        step("addi_d", 1, 0, D, 0, 0, 0);
        step("addi_ex", 1, 0, IE, 0, 0, 0);
        step("addi_wb", 1, 0, IW, 0, 0, 0);
        opcode = 6'h0D;
        step("ori_f", 1, 0, F, 1, 0, 0);
        step("ori_d", 1, 0, D, 1, 0, 0);
        step("ori_ex", 1, 0, IE, 1, 0, 0);
        step("ori_wb", 1, 0, IW, 1, 0, 0);
        opcode = 6'h00;
        step("add_f", 1, 0, F, 2, 0, 0);
        step("add_d", 1, 0, D, 2, 0, 0);
        step("add_ex", 1, 0, RE, 2, 0, 0);
        step("add_wb", 1, 0, RW, 2, 0, 0);
        opcode = 6'h23;
        for (int i = 0; i < 3; i++) step("lw_fwait", 0, 0, F, 3, 0, 0);
        step("lw_f", 1, 0, F, 3, 0, 0);
        step("lw_d", 1, 0, D, 3, 0, 0);
        step("lw_ma", 1, 0, MA, 3, 0, 0);
        for (int i = 0; i < 3; i++) step("lw_mrwait", 0, 0, MR, 3, 0, 0);
        step("lw_mr_edge", 1, 0, MR, 3, 0, 0);
        step("lw_wb", 1, 0, MWB, 3, 0, 0);
        opcode = 6'h2B;
        step("swto_f", 1, 0, F, 4, 0, 0);
        step("swto_d", 1, 0, D, 4, 0, 0);
        step("swto_ma", 1, 0, MA, 4, 0, 0);
        for (int i = 0; i < 4; i++) step("swto_wait", 0, 0, MW, 4, 0, 0);
        step("sw_berr", 1, 0, F, 4, 1, 0);
        step("sw_d", 1, 0, D, 4, 0, 0);
        step("sw_ma", 1, 0, MA, 4, 0, 0);
        step("sw_wait", 0, 0, MW, 4, 0, 0);
        step("sw_done", 1, 0, MW, 4, 0, 0);
        opcode = 6'h05;
        step("bne_f", 1, 0, F, 5, 0, 0);
        step("bne_d", 1, 0, D, 5, 0, 0);
        step("bne_br", 1, 0, BR, 5, 0, 0);
        opcode = 6'h04;
        step("beq_f", 1, 0, F, 6, 0, 0);
        step("beq_d", 1, 0, D, 6, 0, 0);
        step("beq_br", 1, 0, BR, 6, 0, 0);
        opcode = 6'h3F;
        step("ill_f", 1, 0, F, 7, 0, 0);
        step("ill_d", 1, 0, D, 7, 0, 0);
        opcode = 6'h02;
        step("ill_pulse", 1, 0, F, 7, 0, 1);
        step("j_d", 1, 0, D, 7, 0, 0);
`ifdef MC_JUMP_EN
        step("j_exec", 1, 0, J, 7, 0, 0);
        step("j_done", 0, 0, F, 8, 0, 0);
`else
        step("j_illegal", 0, 0, F, 7, 0, 1);
`endif
        for (int i = 0; i < 3; i++) step("f_wait", 0, 0, F, 7 + JC, 0, 0);
        step("f_tmo", 0, 0, F, 7 + JC, 1, 0);
        opcode = 6'h23;
        step("rl_f", 1, 0, F, 7 + JC, 0, 0);
        step("rl_d", 1, 0, D, 7 + JC, 0, 0);
        step("rl_ma", 1, 0, MA, 7 + JC, 0, 0);
        step("rl_mr", 0, 0, MR, 7 + JC, 0, 0);
        step("rst_mid", 1, 1, F, 0, 0, 0);
        step("rst_rel", 0, 0, F, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
